span_fill: RTL
==============

// Module: span_fill
// PURPOSE
//  Consumes {y,x} boundary words produced by the triangle boundary generator via its FIFO.
//  Words arrive in pairs, left then right, for the same row. For each pair, span_fill clips
//  the span to the framebuffer and emits one write per pixel, left to right, with a
//  constant colour. It sits between the boundary FIFO read port and the framebuffer write port.
// PARAMETERS
//  FB_W    320  framebuffer width, pixels
//  FB_H    240  framebuffer height, pixels
//  ADDR_W  17   framebuffer address width; must satisfy 2**ADDR_W >= FB_W*FB_H
//  COL_W   8    pixel colour width
// PORTS
//  clk         in   1       system clock; all state updates on posedge
//  rst         in   1       asynchronous, active-high reset
//  fifo_empty  in   1       boundary FIFO empty
//  fifo_rd     out  1       FIFO read strobe; data is valid on fifo_data in the cycle after
//  fifo_data   in   32      {y[31:16], x[15:0]}, both signed 16-bit integer pixel coordinates
//  color       in   COL_W   fill colour; sampled when the left word is captured
//  fb_we       out  1       framebuffer write request
//  fb_ready    in   1       framebuffer accepts a write when fb_we && fb_ready
//  fb_addr     out  ADDR_W  y*FB_W + x
//  fb_data     out  COL_W   pixel colour
//  busy        out  1       0 only when in IDLE and fifo_empty
//  err         out  1       sticky; set on a pair whose y fields differ; cleared by rst only
// BEHAVIOUR
//  Reset values: fifo_rd=0, fb_we=0, fb_addr=0, fb_data=0, err=0, state=IDLE.
//  Reset asserted mid-span aborts the span with no further writes and no FIFO reads.
//  FSM states and transitions:
//   IDLE   if !fifo_empty: fifo_rd=1 for one cycle, go to GETL.
//   GETL   latch yl, xl, col. If !fifo_empty: fifo_rd=1, go to GETR; else go to WAITR.
//   WAITR  hold until !fifo_empty, then fifo_rd=1, go to GETR.
//   GETR   latch yr, xr, go to CHECK.
//   CHECK  - Drop the pair and go to IDLE if yl!=yr (also set err), or yl<0, or yl>=FB_H,
//            or xr<0, or xl>=FB_W, or xl>xr.
//          - Otherwise clip cx=max(xl,0) and ex=min(xr,FB_W-1), then go to FILL.
//          - Comparisons are signed 16-bit.
//   FILL   - fb_we=1, fb_addr=yl*FB_W+cx, fb_data=col.
//          - fb_addr, fb_data and fb_we stay stable until accepted (fb_we && fb_ready).
//          - On accept: if cx==ex, drop fb_we in the next cycle and go to IDLE;
//            otherwise cx+=1 and fb_addr+=1.
//  Timing:
//   - At most one FIFO read is outstanding. fifo_rd is never asserted while fifo_empty=1.
//   - Back-to-back accepted writes run at 1 pixel/clk when fb_ready is held high.
//   - Overhead from pair-available to first fb_we: 4 clk (IDLE, GETL, GETR, CHECK).
//  Arithmetic:
//   - Row base yl*FB_W is computed once, in CHECK; in FILL fb_addr increments only.
//   - The multiply is ADDR_W wide, unsigned, and is performed only after the range checks pass.
//   - The span is inclusive. Single-pixel span (xl==xr) produces exactly one write.
//  Simultaneous events:
//   - fifo_empty rising in the same cycle as fifo_rd: not possible, since reads are gated
//     on !fifo_empty.
//   - fb_ready low in FILL: stall with all outputs frozen, no FIFO reads.
//   - A change on color during a span does not affect that span.
// STRUCTURE
//  - Shared header gpu_defs.vh: FB_W, FB_H, ADDR_W defaults; span_fill state encodings
//    (3-bit); and the {y,x} word field macros shared with the boundary generator.
//  - One sub-module, span_clip: combinational. Takes yl, xl, yr, xr and produces
//    drop, cx, ex and err_pair. It is instantiated once and used in CHECK.
//  - Everything else (FSM, row-base multiply register, address counter) lives in span_fill.
// TESTING
//  1. Pair {5,10},{5,13}, fb_ready=1, color=8'hA5
//     -> 4 writes, addr 1610..1613 consecutive cycles, data A5, then busy=0.
//  2. Pair {0,-4},{0,2}
//     -> writes addr 0,1,2 only.
//     Pair {239,318},{239,400}
//     -> writes 76798, 76799 only.
//  3. Pairs {-1,0},{-1,5} / {240,0},{240,5} / {3,9},{3,8} / {3,-9},{3,-2}
//     -> zero fb_we, FIFO drained, err=0.
//  4. Pair {7,1},{8,1}
//     -> no writes; err=1 and stays 1 across later valid pairs until rst.
//  5. Pair {2,0},{2,3} with fb_ready toggling 1,0,0,1,1,0,1
//     -> addrs 640..643 each held until accepted, exactly 4 accepts.
//  6. rst pulsed during 3rd pixel of span {1,0},{1,9}
//     -> fb_we=0 and fifo_rd=0 immediately (async).
//     After rst release the next pair in the FIFO is treated as a left word.

Source files
------------

// File: rtl/span_fill_pkg.sv
// span_fill_pkg: shared definitions for the span filler and the boundary generator.
//   - framebuffer geometry and address/colour width defaults
//   - span_fill FSM state encoding (3-bit)
//   - {y,x} boundary word layout: y in [31:16], x in [15:0], both signed 16-bit
package span_fill_pkg;

    localparam int FB_W_DEF   = 320;
    localparam int FB_H_DEF   = 240;
    localparam int ADDR_W_DEF = 17;
    localparam int COL_W_DEF  = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GETL  = 3'd1,
        S_WAITR = 3'd2,
        S_GETR  = 3'd3,
        S_CHECK = 3'd4,
        S_FILL  = 3'd5
    } state_t;

    typedef struct packed {
        logic signed [15:0] y;
        logic signed [15:0] x;
    } bword_t;

endpackage

// File: rtl/span_clip.sv
// span_clip: combinational range check and horizontal clip of one boundary pair.
//   yl, xl, yr, xr : signed 16-bit left/right boundary coordinates
//   drop           : pair produces no pixels
//   err_pair       : left and right words disagree on the row
//   cx, ex         : first/last pixel column after clipping (valid when !drop)
module span_clip #(
    parameter int FB_W = 320,
    parameter int FB_H = 240
) (
    input  logic signed [15:0] yl,
    input  logic signed [15:0] xl,
    input  logic signed [15:0] yr,
    input  logic signed [15:0] xr,
    output logic               drop,
    output logic               err_pair,
    output logic signed [15:0] cx,
    output logic signed [15:0] ex
);
    localparam logic signed [15:0] W    = 16'(FB_W);
    localparam logic signed [15:0] H    = 16'(FB_H);
    localparam logic signed [15:0] XMAX = 16'(FB_W - 1);

    always_comb begin
        err_pair = (yl != yr);
        // Span entirely off-screen, off-row, or inverted
        drop     = err_pair || (yl < 0) || (yl >= H) || (xr < 0) || (xl >= W) || (xl > xr);
        cx       = (xl < 0)    ? 16'sd0 : xl;
        ex       = (xr > XMAX) ? XMAX   : xr;
    end

endmodule

// File: rtl/span_fill.sv
// span_fill: turns left/right boundary word pairs from the boundary FIFO into
// clipped, left-to-right framebuffer pixel writes of a constant colour.
//   clk, rst        : clock, async active-high reset
//   fifo_empty/rd   : FIFO status / read strobe (data arrives the cycle after fifo_rd)
//   fifo_data       : {y[31:16], x[15:0]} signed boundary word
//   color           : fill colour, captured with the left word
//   fb_we/ready     : write request / handshake (accept = fb_we && fb_ready)
//   fb_addr/data    : y*FB_W + x / pixel colour
//   busy            : low only when idle with nothing queued
//   err             : sticky row-mismatch flag
module span_fill
    import span_fill_pkg::*;
#(
    parameter int FB_W   = FB_W_DEF,
    parameter int FB_H   = FB_H_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int COL_W  = COL_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    output logic              fifo_rd,
    input  logic [31:0]       fifo_data,
    input  logic [COL_W-1:0]  color,
    output logic              fb_we,
    input  logic              fb_ready,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [COL_W-1:0]  fb_data,
    output logic              busy,
    output logic              err
);
    state_t             state, state_nxt;
    logic               rd_c;
    logic signed [15:0] yl, xl, yr, xr, cx, ex;
    logic signed [15:0] cx_c, ex_c;
    logic               drop, err_pair;
    logic [COL_W-1:0]   col;
    logic [ADDR_W-1:0]  mul_y, row_base;
    bword_t             w;

    assign w = bword_t'(fifo_data);

    span_clip #(.FB_W(FB_W), .FB_H(FB_H)) u_clip (
        .yl(yl), .xl(xl), .yr(yr), .xr(xr),
        .drop(drop), .err_pair(err_pair), .cx(cx_c), .ex(ex_c)
    );

    // Multiplier operand is held at zero unless the pair survived the checks,
    // so a negative or out-of-range row never feeds the multiply.
    assign mul_y    = drop ? '0 : ADDR_W'($unsigned(yl));
    assign row_base = mul_y * ADDR_W'(FB_W);

    always_comb begin
        state_nxt = state;
        rd_c      = 1'b0;
        case (state)
            S_IDLE: if (!fifo_empty) begin
                rd_c      = 1'b1;
                state_nxt = S_GETL;
            end
            S_GETL, S_WAITR: begin
                if (!fifo_empty) begin
                    rd_c      = 1'b1;
                    state_nxt = S_GETR;
                end else begin
                    state_nxt = S_WAITR;
                end
            end
            S_GETR:  state_nxt = S_CHECK;
            S_CHECK: state_nxt = drop ? S_IDLE : S_FILL;
            S_FILL:  if (fb_ready && (cx == ex)) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Reset must silence the read strobe immediately, not at the next edge.
    assign fifo_rd = rd_c & ~rst;
    assign busy    = !((state == S_IDLE) && fifo_empty);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            yl      <= '0;
            xl      <= '0;
            yr      <= '0;
            xr      <= '0;
            cx      <= '0;
            ex      <= '0;
            col     <= '0;
            fb_we   <= 1'b0;
            fb_addr <= '0;
            fb_data <= '0;
            err     <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_GETL: begin
                    yl  <= w.y;
                    xl  <= w.x;
                    col <= color;
                end
                S_GETR: begin
                    yr <= w.y;
                    xr <= w.x;
                end
                S_CHECK: begin
                    if (drop) begin
                        err <= err | err_pair;
                    end else begin
                        cx      <= cx_c;
                        ex      <= ex_c;
                        fb_addr <= row_base + ADDR_W'($unsigned(cx_c));
                        fb_data <= col;
                        fb_we   <= 1'b1;
                    end
                end
                S_FILL: begin
                    if (fb_ready) begin
                        if (cx == ex) begin
                            fb_we <= 1'b0;
                        end else begin
                            cx      <= cx + 16'sd1;
                            fb_addr <= fb_addr + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
